axi_addr_ch_txs: RTL and testbench



---
 rtl/axi_addr_ch_txs_pkg.sv | 29 ++
 rtl/synch_fifo.sv | 44 ++++
 rtl/axi_addr_ch_txs.sv | 138 +++++++++++++
 tb/tb_axi_addr_ch_txs.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_addr_ch_txs_pkg.sv
// Shared field layout for packed AXI address-channel beats; the receiver imports
// the same package so both ends agree on bit positions.
package axi_addr_ch_txs_pkg;

    localparam int LEN_LSB   = 0;
    localparam int SIZE_LSB  = 8;
    localparam int BURST_LSB = 11;
    localparam int PROT_LSB  = 13;
    localparam int CACHE_LSB = 16;
    localparam int LOCK_BIT  = 20;
    localparam int ID_LSB    = 21;

    function automatic int addr_lsb(input int id_w);
        return ID_LSB + id_w;
    endfunction

    function automatic int user_lsb(input int id_w, input int addr_w);
        return ID_LSB + id_w + addr_w;
    endfunction

    function automatic int packed_width(input int id_w, input int addr_w, input int user_w);
        return id_w + user_w + addr_w + 21;
    endfunction

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/synch_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is visible combinationally
// on rd_data whenever empty is low.
module synch_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [FIFO_DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values, independent of the order the always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which words are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axi_addr_ch_txs.sv
// Master-side AXI address channel transmitter: FIFO-queued requests, registered
// VALID/READY output stage and an outstanding-transaction credit counter.
module axi_addr_ch_txs
    import axi_addr_ch_txs_pkg::*;
#(
    parameter int BUF_SZ          = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int USER_WIDTH      = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                   tx_clk,
    input  logic                                   reset,
    input  logic [ID_WIDTH-1:0]                    in_id,
    input  logic [ADDR_WIDTH-1:0]                  in_addr,
    input  logic [7:0]                             in_len,
    input  logic [2:0]                             in_size,
    input  logic [1:0]                             in_burst,
    input  logic [2:0]                             in_prot,
    input  logic [3:0]                             in_cache,
    input  logic [USER_WIDTH-1:0]                  in_user,
    input  logic                                   in_lock,
    input  logic                                   in_valid,
    output logic                                   out_ready,
    output logic [ID_WIDTH-1:0]                    m_id,
    output logic [ADDR_WIDTH-1:0]                  m_addr,
    output logic [7:0]                             m_len,
    output logic [2:0]                             m_size,
    output logic [1:0]                             m_burst,
    output logic [2:0]                             m_prot,
    output logic [3:0]                             m_cache,
    output logic [USER_WIDTH-1:0]                  m_user,
    output logic                                   m_lock,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    input  logic                                   i_txn_done,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]  o_outstanding,
    output logic                                   o_err,
    output logic                                   buf_empty
);
    localparam int PW        = packed_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int CW        = cnt_width(MAX_OUTSTANDING);
    localparam int ADDR_LSB  = addr_lsb(ID_WIDTH);
    localparam int USER_LSB  = user_lsb(ID_WIDTH, ADDR_WIDTH);

    logic [PW-1:0] in_word;
    logic [PW-1:0] head_word;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          load;
    logic          done_ok;
    logic [CW-1:0] cnt;

    // NOTE: the default assignment up front guarantees every bit is written on
    // every pass, so no latch can be inferred.
    always_comb begin
        in_word                                = '0;
        in_word[LEN_LSB +: 8]                  = in_len;
        in_word[SIZE_LSB +: 3]                 = in_size;
        in_word[BURST_LSB +: 2]                = in_burst;
        in_word[PROT_LSB +: 3]                 = in_prot;
        in_word[CACHE_LSB +: 4]                = in_cache;
        in_word[LOCK_BIT]                      = in_lock;
        in_word[ID_LSB +: ID_WIDTH]            = in_id;
        in_word[ADDR_LSB +: ADDR_WIDTH]        = in_addr;
        in_word[USER_LSB +: USER_WIDTH]        = in_user;
    end

    assign out_ready = ~fifo_full;
    assign buf_empty = fifo_empty;
    assign push      = in_valid & out_ready;
    // The credit check uses the registered count only, so a same-cycle
    // completion never lets an extra transaction slip past the limit.
    assign load      = ~fifo_empty & (~m_valid | m_ready) & (cnt < CW'(MAX_OUTSTANDING));
    assign done_ok   = i_txn_done & (cnt != '0);

    synch_fifo #(
        .DW         (PW),
        .FIFO_DEPTH (BUF_SZ)
    ) u_fifo (
        .clk     (tx_clk),
        .rst_n   (~reset),
        .wr_en   (push),
        .wr_data (in_word),
        .rd_en   (load),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output stage: every AXI-facing signal comes straight from a flop and
    // only changes on a load, so fields stay stable while VALID waits on READY.
    always_ff @(posedge tx_clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_id    <= '0;
            m_addr  <= '0;
            m_len   <= '0;
            m_size  <= '0;
            m_burst <= '0;
            m_prot  <= '0;
            m_cache <= '0;
            m_user  <= '0;
            m_lock  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_len   <= head_word[LEN_LSB +: 8];
            m_size  <= head_word[SIZE_LSB +: 3];
            m_burst <= head_word[BURST_LSB +: 2];
            m_prot  <= head_word[PROT_LSB +: 3];
            m_cache <= head_word[CACHE_LSB +: 4];
            m_lock  <= head_word[LOCK_BIT];
            m_id    <= head_word[ID_LSB +: ID_WIDTH];
            m_addr  <= head_word[ADDR_LSB +: ADDR_WIDTH];
            m_user  <= head_word[USER_LSB +: USER_WIDTH];
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            cnt   <= '0;
            o_err <= 1'b0;
        end else begin
            case ({load, done_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (i_txn_done && (cnt == '0)) o_err <= 1'b1;
        end
    end

    assign o_outstanding = cnt;

endmodule

// File: tb/tb_axi_addr_ch_txs.sv
// Directed bench for axi_addr_ch_txs: expected beats are queued at request
// acceptance and compared by a monitor at every AXI handshake.
module tb_axi_addr_ch_txs;
    import axi_addr_ch_txs_pkg::*;

    localparam int MAX_OUT = 8;
    localparam int CW      = cnt_width(MAX_OUT);

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
        logic [3:0]  cache;
        logic [1:0]  user;
        logic        lock;
    } beat_t;

    logic          tx_clk = 1'b0;
    logic          reset  = 1'b1;
    logic [7:0]    in_id  = '0;
    logic [31:0]   in_addr = '0;
    logic [7:0]    in_len = '0;
    logic [2:0]    in_size = '0;
    logic [1:0]    in_burst = '0;
    logic [2:0]    in_prot = '0;
    logic [3:0]    in_cache = '0;
    logic [1:0]    in_user = '0;
    logic          in_lock = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready;
    logic [7:0]    m_id;
    logic [31:0]   m_addr;
    logic [7:0]    m_len;
    logic [2:0]    m_size;
    logic [1:0]    m_burst;
    logic [2:0]    m_prot;
    logic [3:0]    m_cache;
    logic [1:0]    m_user;
    logic          m_lock;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          i_txn_done;
    logic [CW-1:0] o_outstanding;
    logic          o_err;
    logic          buf_empty;

    logic done_manual = 1'b0;
    logic done_auto   = 1'b0;
    logic auto_done   = 1'b0;
    logic hs_seen     = 1'b0;
    assign i_txn_done = done_manual | done_auto;

    int    errors = 0;
    int    checks = 0;
    int    hs_count = 0;
    int    cyc = 0;
    int    mark = -1;
    int    mark_cyc = 0;
    int    last_hs_cyc = 0;
    beat_t sb[$];

    axi_addr_ch_txs #(
        .BUF_SZ          (16),
        .ADDR_WIDTH      (32),
        .ID_WIDTH        (8),
        .USER_WIDTH      (2),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .tx_clk        (tx_clk),
        .reset         (reset),
        .in_id         (in_id),
        .in_addr       (in_addr),
        .in_len        (in_len),
        .in_size       (in_size),
        .in_burst      (in_burst),
        .in_prot       (in_prot),
        .in_cache      (in_cache),
        .in_user       (in_user),
        .in_lock       (in_lock),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .m_id          (m_id),
        .m_addr        (m_addr),
        .m_len         (m_len),
        .m_size        (m_size),
        .m_burst       (m_burst),
        .m_prot        (m_prot),
        .m_cache       (m_cache),
        .m_user        (m_user),
        .m_lock        (m_lock),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .i_txn_done    (i_txn_done),
        .o_outstanding (o_outstanding),
        .o_err         (o_err),
        .buf_empty     (buf_empty)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    // Derived fields vary with id/addr so a swapped bit lane shows up.
    task automatic drive(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        in_id    = id;
        in_addr  = addr;
        in_len   = len;
        in_size  = len[2:0];
        in_burst = 2'b01;
        in_prot  = id[2:0];
        in_cache = addr[9:6];
        in_user  = id[1:0];
        in_lock  = id[0];
        in_valid = 1'b1;
    endtask

    task automatic push(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        drive(id, addr, len);
        for (int n = 0; n < 200 && !out_ready; n++) tick();
        check("push_accept", 128'(out_ready), 128'(1));
        tick();
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int n = 0; n < budget && hs_count < target; n++) tick();
        check("hs_count", 128'(hs_count), 128'(target));
    endtask

    task automatic pulse_done(input int cycles);
        done_manual = 1'b1;
        for (int n = 0; n < cycles; n++) tick();
        done_manual = 1'b0;
    endtask

    // Monitor: handshakes and acceptances are both decided at the next rising
    // edge, so sampling on the falling edge sees exactly what that edge will use.
    always @(negedge tx_clk) begin
        beat_t got;
        beat_t exp;
        cyc++;
        hs_seen = 1'b0;
        if (reset) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                got = '{m_id, m_addr, m_len, m_size, m_burst, m_prot, m_cache, m_user, m_lock};
                if (sb.size() == 0) begin
                    check("sb_has_entry", 128'(sb.size()), 128'(1));
                end else begin
                    exp = sb.pop_front();
                    check("beat_addr", 128'(got.addr), 128'(exp.addr));
                    check("beat_fields", 128'(got), 128'(exp));
                end
                if (hs_count == mark) mark_cyc = cyc;
                last_hs_cyc = cyc;
                hs_count++;
                hs_seen = auto_done;
            end
            if (in_valid && out_ready)
                sb.push_back('{in_id, in_addr, in_len, in_size, in_burst, in_prot, in_cache, in_user, in_lock});
        end
    end

    always @(posedge tx_clk) begin
        #1;
        done_auto = hs_seen;
    end

    initial begin
        bit saw_full;
        int base;

        // Reset held with a request pending: nothing may be accepted or issued.
        drive(8'h05, 32'h0000_1000, 8'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_m_valid", 128'(m_valid), 128'(0));
            check("rst_out_ready", 128'(out_ready), 128'(1));
            check("rst_outstanding", 128'(o_outstanding), 128'(0));
        end
        check("rst_buf_empty", 128'(buf_empty), 128'(1));
        check("rst_m_addr", 128'(m_addr), 128'(0));

        // Release: accept at edge N, VALID after edge N+1.
        reset = 1'b0;
        tick();
        in_valid = 1'b0;
        check("lat_n_m_valid", 128'(m_valid), 128'(0));
        check("lat_n_buf_empty", 128'(buf_empty), 128'(0));
        tick();
        check("lat_n1_m_valid", 128'(m_valid), 128'(1));

        // Backpressure: held beat must stay stable for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            check("bp_m_valid", 128'(m_valid), 128'(1));
            check("bp_fields", {m_id, m_addr, m_len}, {8'h05, 32'h0000_1000, 8'd3});
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("bp_after_hs_valid", 128'(m_valid), 128'(0));
        check("bp_outstanding", 128'(o_outstanding), 128'(1));
        check("bp_hs_count", 128'(hs_count), 128'(1));
        pulse_done(1);
        check("bp_done_outstanding", 128'(o_outstanding), 128'(0));
        check("bp_no_err", 128'(o_err), 128'(0));

        // Streaming: back-to-back handshakes with completions returned promptly.
        m_ready   = 1'b1;
        auto_done = 1'b1;
        mark      = hs_count;
        base      = hs_count;
        saw_full  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!out_ready) saw_full = 1'b1;
            push(8'(i), 32'(i) * 32'h40, 8'(i));
        end
        in_valid = 1'b0;
        wait_hs(base + 32, 100);
        mark = -1;
        check("stream_no_bubble", 128'(last_hs_cyc - mark_cyc), 128'(31));
        check("stream_never_full", 128'(saw_full), 128'(0));
        repeat (3) tick();
        check("stream_outstanding", 128'(o_outstanding), 128'(0));
        check("stream_no_err", 128'(o_err), 128'(0));

        // Credit limit: 12 requests, no completions -> only 8 issue.
        auto_done = 1'b0;
        base      = hs_count;
        for (int i = 0; i < 12; i++) push(8'(8'h80 + i), 32'h0002_0000 + 32'(i) * 32'h100, 8'd1);
        in_valid = 1'b0;
        wait_hs(base + 8, 50);
        repeat (5) tick();
        check("credit_hs8", 128'(hs_count - base), 128'(8));
        check("credit_outstanding8", 128'(o_outstanding), 128'(MAX_OUT));
        check("credit_buf_not_empty", 128'(buf_empty), 128'(0));
        check("credit_blocked_valid", 128'(m_valid), 128'(0));
        pulse_done(1);
        wait_hs(base + 9, 20);
        repeat (3) tick();
        check("credit_hs9", 128'(hs_count - base), 128'(9));
        check("credit_still8", 128'(o_outstanding), 128'(MAX_OUT));
        pulse_done(11);
        repeat (3) tick();
        check("credit_hs12", 128'(hs_count - base), 128'(12));
        check("credit_drained", 128'(o_outstanding), 128'(0));
        check("credit_no_err", 128'(o_err), 128'(0));
        check("credit_buf_empty", 128'(buf_empty), 128'(1));

        // Full: 1 held in the output register + 16 in the FIFO, 18th stalls.
        m_ready = 1'b0;
        base    = hs_count;
        for (int i = 0; i < 17; i++) push(8'(8'h40 + i), 32'h0000_8000 + 32'(i) * 32'h10, 8'(i));
        check("full_out_ready", 128'(out_ready), 128'(0));
        check("full_buf_empty", 128'(buf_empty), 128'(0));
        drive(8'h51, 32'h0000_8110, 8'd17);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full_stall_ready", 128'(out_ready), 128'(0));
            check("full_held_addr", 128'(m_addr), 128'(32'h0000_8000));
        end
        m_ready   = 1'b1;
        auto_done = 1'b1;
        for (int n = 0; n < 20 && !out_ready; n++) tick();
        check("full_reopen", 128'(out_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        wait_hs(base + 18, 100);
        repeat (4) tick();
        check("full_drained_sb", 128'(sb.size()), 128'(0));
        check("full_outstanding", 128'(o_outstanding), 128'(0));

        // Completion with nothing outstanding sets the sticky error.
        auto_done = 1'b0;
        pulse_done(1);
        check("err_set", 128'(o_err), 128'(1));
        check("err_cnt_zero", 128'(o_outstanding), 128'(0));

        // Load and completion in the same cycle at cnt=3 leave the count alone.
        base = hs_count;
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 32'h0003_0000 + 32'(i) * 32'h40, 8'd0);
        in_valid = 1'b0;
        wait_hs(base + 3, 20);
        repeat (2) tick();
        check("simul_pre_cnt3", 128'(o_outstanding), 128'(3));
        drive(8'hC3, 32'h0003_00C0, 8'd2);
        tick();
        in_valid    = 1'b0;
        done_manual = 1'b1;
        tick();
        done_manual = 1'b0;
        check("simul_cnt3", 128'(o_outstanding), 128'(3));
        check("simul_loaded", 128'(m_valid), 128'(1));
        tick();
        pulse_done(4);
        check("simul_drained", 128'(o_outstanding), 128'(0));
        check("err_sticky", 128'(o_err), 128'(1));

        // Reset mid-transaction drops held and queued entries.
        m_ready = 1'b0;
        push(8'h21, 32'h0004_0000, 8'd1);
        push(8'h22, 32'h0004_0040, 8'd1);
        in_valid = 1'b0;
        tick();
        check("mid_pre_valid", 128'(m_valid), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_m_valid", 128'(m_valid), 128'(0));
        check("mid_buf_empty", 128'(buf_empty), 128'(1));
        check("mid_out_ready", 128'(out_ready), 128'(1));
        check("mid_m_addr", 128'(m_addr), 128'(0));
        check("mid_outstanding", 128'(o_outstanding), 128'(0));
        check("mid_err_cleared", 128'(o_err), 128'(0));
        repeat (3) tick();
        check("mid_stays_idle", 128'(m_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
